// File: rtl/countdown_timer_if.sv
// Control and status bundle for countdown_timer: load/enable/mode in, count and
// status flags out.
interface countdown_timer_if #(
  parameter int WIDTH = 4
);
  logic             enable;
  logic             load;
  logic [WIDTH-1:0] load_value;
  logic             periodic;
  logic [WIDTH-1:0] count_out;
  logic             expired;
  logic             busy;
  logic             done;

  modport master (
    output enable, load, load_value, periodic,
    input  count_out, expired, busy, done
  );

  modport slave (
    input  enable, load, load_value, periodic,
    output count_out, expired, busy, done
  );
endinterface

// File: rtl/countdown_timer.sv
// Loadable down-counter timer with one-shot and auto-reload modes; flags the
// 1->0 terminal event with a registered one-cycle expired pulse.
//
// state | meaning
// IDLE  | no count loaded (reset or load of zero); enable ignored
// RUN   | counting down on enabled cycles
// DONE  | one-shot finished, count held at zero until load or reset
module countdown_timer #(
  parameter int WIDTH = 4
) (
  input  logic                clock_i,
  input  logic                reset_i,
  countdown_timer_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] ZERO = '0;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             expired_q, expired_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  always_ff @(posedge clock_i) begin
    if (!reset_i) begin
      state_q   <= IDLE;
      count_q   <= ZERO;
      reload_q  <= ZERO;
      expired_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      reload_q  <= reload_d;
      expired_q <= expired_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    reload_d  = reload_q;
    expired_d = 1'b0;

    if (bus.load) begin
      // A load on the terminal edge wins and swallows the expired pulse.
      reload_d = bus.load_value;
      count_d  = bus.load_value;
      state_d  = (bus.load_value != ZERO) ? RUN : IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = IDLE;
        end
        RUN: begin
          if (bus.enable) begin
            if (count_q == ONE) begin
              expired_d = 1'b1;
              if (bus.periodic) begin
                count_d = reload_q;
              end else begin
                count_d = ZERO;
                state_d = DONE;
              end
            end else if (count_q != ZERO) begin
              count_d = count_q - ONE;
            end
          end
        end
        DONE: begin
          count_d = ZERO;
        end
        default: begin
          state_d = IDLE;
          count_d = ZERO;
        end
      endcase
    end

    // Status flags are registered from the next state so they line up with count_out.
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  assign bus.count_out = count_q;
  assign bus.expired   = expired_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer: per-cycle comparison against a
// behavioural model plus directed literal expectations.
module tb_countdown_timer;

  localparam int WIDTH = 4;

  logic clock;
  logic reset;

  countdown_timer_if #(.WIDTH(WIDTH)) tb_if ();

  countdown_timer #(.WIDTH(WIDTH)) dut (
    .clock_i (clock),
    .reset_i (reset),
    .bus     (tb_if.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: 0=idle, 1=running, 2=finished one-shot.
  int m_mode   = 0;
  int m_count  = 0;
  int m_reload = 0;
  int m_exp    = 0;
  bit m_valid  = 1'b0;

  always @(posedge clock) begin
    m_exp = 0;
    if (!reset) begin
      m_mode = 0; m_count = 0; m_reload = 0; m_valid = 1'b1;
    end else if (tb_if.load) begin
      m_reload = int'(tb_if.load_value);
      m_count  = m_reload;
      m_mode   = (m_reload == 0) ? 0 : 1;
    end else if (m_mode == 1 && tb_if.enable) begin
      if (m_count == 1) begin
        m_exp = 1;
        if (tb_if.periodic) m_count = m_reload;
        else begin
          m_count = 0;
          m_mode  = 2;
        end
      end else begin
        m_count = m_count - 1;
      end
    end
  end

  always @(negedge clock) begin
    if (m_valid) begin
      chk("model count_out", int'(tb_if.count_out), m_count);
      chk("model expired", int'(tb_if.expired), m_exp);
      chk("model busy", int'(tb_if.busy), (m_mode == 1) ? 1 : 0);
      chk("model done", int'(tb_if.done), (m_mode == 2) ? 1 : 0);
    end
  end

  task automatic step(input bit rst, input bit ld, input int lv, input bit en, input bit per);
    reset            = rst;
    tb_if.load       = ld;
    tb_if.load_value = WIDTH'(lv);
    tb_if.enable     = en;
    tb_if.periodic   = per;
    @(posedge clock);
    #1;
  endtask

  task automatic chk_out(input string name, input int cnt, input int ex, input int bs, input int dn);
    chk({name, " count_out"}, int'(tb_if.count_out), cnt);
    chk({name, " expired"}, int'(tb_if.expired), ex);
    chk({name, " busy"}, int'(tb_if.busy), bs);
    chk({name, " done"}, int'(tb_if.done), dn);
  endtask

  initial begin
    int pen[6];
    int pcnt[6];
    int pexp[6];
    int edges;
    bit seen;

    reset = 1'b0;
    tb_if.load = 1'b1; tb_if.load_value = 4'd5; tb_if.enable = 1'b1; tb_if.periodic = 1'b0;

    // Reset overrides load and enable
    step(0, 1, 5, 1, 0);
    step(0, 1, 5, 1, 0);
    chk_out("reset", 0, 0, 0, 0);

    // One-shot 3
    step(1, 1, 3, 0, 0);
    chk_out("os load", 3, 0, 1, 0);
    step(1, 0, 0, 1, 0); chk_out("os 2", 2, 0, 1, 0);
    step(1, 0, 0, 1, 0); chk_out("os 1", 1, 0, 1, 0);
    step(1, 0, 0, 1, 0); chk_out("os 0", 0, 1, 0, 1);
    for (int i = 0; i < 6; i++) begin
      step(1, 0, 0, 1, 0);
      chk_out("os hold", 0, 0, 0, 1);
    end

    // Periodic 2 with enable gaps
    step(1, 1, 2, 0, 1);
    chk_out("per load", 2, 0, 1, 0);
    pen  = '{1, 0, 1, 1, 0, 1};
    pcnt = '{1, 1, 2, 1, 1, 2};
    pexp = '{0, 0, 1, 0, 0, 1};
    for (int i = 0; i < 6; i++) begin
      step(1, 0, 0, pen[i][0], 1);
      chk_out("per gap", pcnt[i], pexp[i], 1, 0);
    end

    // Load 15 one-shot: count enabled edges to expiry
    step(1, 1, 15, 0, 0);
    chk_out("ld15", 15, 0, 1, 0);
    edges = 0;
    seen  = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      step(1, 0, 0, 1, 0);
      edges++;
      if (tb_if.expired) seen = 1'b1;
    end
    chk("ld15 expiry seen", int'(seen), 1);
    chk("ld15 enabled edges", edges, 15);
    chk_out("ld15 end", 0, 1, 0, 1);

    // Load 0 goes idle, never expires
    step(1, 1, 0, 1, 1);
    chk_out("ld0", 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, 1, 1);
      chk_out("ld0 en", 0, 0, 0, 0);
    end

    // Periodic reload of 1 expires on every enabled cycle
    step(1, 1, 1, 0, 1);
    chk_out("per1 load", 1, 0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, 1, 1);
      chk_out("per1 en", 1, 1, 1, 0);
    end
    step(1, 0, 0, 0, 1);
    chk_out("per1 dis", 1, 0, 1, 0);

    // Load collides with terminal edge
    step(1, 1, 2, 0, 0);
    step(1, 0, 0, 1, 0);
    chk_out("coll pre", 1, 0, 1, 0);
    step(1, 1, 5, 1, 0);
    chk_out("coll load", 5, 0, 1, 0);
    step(1, 0, 0, 1, 0);
    chk_out("coll run", 4, 0, 1, 0);

    // Reset collides with terminal edge
    step(1, 1, 2, 0, 0);
    step(1, 0, 0, 1, 0);
    chk_out("rst pre", 1, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    chk_out("rst coll", 0, 0, 0, 0);
    step(1, 0, 0, 1, 0);
    chk_out("rst after", 0, 0, 0, 0);

    // Mid-count mode change only matters at the terminal edge
    step(1, 1, 3, 0, 0);
    step(1, 0, 0, 1, 1);
    step(1, 0, 0, 1, 0);
    step(1, 0, 0, 1, 1);
    chk_out("mode late", 3, 1, 1, 0);

    step(1, 0, 0, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
